// File: rtl/iter_muldiv.sv
// Iterative unsigned multiply/divide unit: shift-add MUL and restoring DIV, one bit per clock.
// Results, busy and done are registered; div_by_zero is sticky until the next accepted start.
module iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluop,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} stateT;

    stateT             state, stateNext;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  mcand, divisor, rem, quo;
    logic [2*WIDTH:0]  acc, accNext;
    logic [WIDTH:0]    addSum, remShift, trialDiff;
    logic [WIDTH-1:0]  remNext, quoNext;
    logic              accept, lastIter;

    always_comb begin
        accept    = start && (aluop == OP_MUL || aluop == OP_DIV)
                    && (state == IDLE || state == DONE);
        lastIter  = (count == CW'(1));
        stateNext = state;
        case (state)
            IDLE, DONE: begin
                stateNext = IDLE;
                if (accept) begin
                    if (aluop == OP_MUL)  stateNext = MUL_RUN;
                    else if (b == '0)     stateNext = DONE;
                    else                  stateNext = DIV_RUN;
                end
            end
            MUL_RUN, DIV_RUN: begin
                if (lastIter) stateNext = DONE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Shift-add step: add into the upper half (carry lands in the extra top bit), then shift right.
    always_comb begin
        addSum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mcand} : '0);
        accNext = {1'b0, addSum, acc[WIDTH-1:1]};
    end

    // Restoring step: since rem < divisor, bit WIDTH of the trial difference is the borrow.
    always_comb begin
        remShift  = {rem, quo[WIDTH-1]};
        trialDiff = remShift - {1'b0, divisor};
        remNext   = trialDiff[WIDTH] ? remShift[WIDTH-1:0] : trialDiff[WIDTH-1:0];
        quoNext   = {quo[WIDTH-2:0], ~trialDiff[WIDTH]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            mcand       <= '0;
            divisor     <= '0;
            acc         <= '0;
            rem         <= '0;
            quo         <= '0;
            result_lo   <= '0;
            result_hi   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state <= stateNext;
            busy  <= (stateNext == MUL_RUN) || (stateNext == DIV_RUN);
            done  <= (stateNext == DONE);
            if (accept) begin
                count       <= CW'(WIDTH);
                mcand       <= a;
                divisor     <= b;
                acc         <= {{(WIDTH + 1){1'b0}}, b};
                rem         <= '0;
                quo         <= a;
                div_by_zero <= 1'b0;
                if (aluop == OP_DIV && b == '0) begin
                    result_lo   <= '1;
                    result_hi   <= a;
                    div_by_zero <= 1'b1;
                end
            end else if (state == MUL_RUN) begin
                acc   <= accNext;
                count <= count - CW'(1);
                if (lastIter) begin
                    result_lo <= accNext[WIDTH-1:0];
                    result_hi <= accNext[2*WIDTH-1:WIDTH];
                end
            end else if (state == DIV_RUN) begin
                rem   <= remNext;
                quo   <= quoNext;
                count <= count - CW'(1);
                if (lastIter) begin
                    result_lo <= quoNext;
                    result_hi <= remNext;
                end
            end
        end
    end

endmodule

// File: tb/tb_iter_muldiv.sv
// Bench for iter_muldiv: directed cases plus randomized MUL/DIV checked against an arithmetic model.
module tb_iter_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic [3:0]   aluop;
    logic [W-1:0] result_lo, result_hi;
    logic         busy, done, div_by_zero;

    int total = 0;
    int bad   = 0;

    iter_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .aluop(aluop),
        .result_lo(result_lo), .result_hi(result_hi),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic; lat counts accept edge to the edge that samples done=1.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi,
                                  output logic dz, output int lat);
        logic [63:0] p;
        if (op == 4'h2) begin
            p   = {32'b0, x} * {32'b0, y};
            lo  = p[31:0];
            hi  = p[63:32];
            dz  = 1'b0;
            lat = W + 1;
        end else if (y == 0) begin
            lo  = '1;
            hi  = x;
            dz  = 1'b1;
            lat = 1;
        end else begin
            lo  = x / y;
            hi  = x % y;
            dz  = 1'b0;
            lat = W + 1;
        end
    endfunction

    task automatic startOp(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; aluop = op; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; aluop = 4'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic waitDone(output int n, output int busyCnt, input int intrudeAt);
        n = 0; busyCnt = 0;
        while (!done && n < 200) begin
            if (busy) busyCnt++;
            if (n == intrudeAt) begin
                start = 1'b1; aluop = 4'h3; a = 8; b = 2;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
    endtask

    task automatic runCheck(input string tag, input logic [3:0] op, input logic [W-1:0] x,
                            input logic [W-1:0] y, input int intrudeAt, input bit hold);
        logic [W-1:0] eLo, eHi;
        logic         eDz;
        int           eLat, n, bc;
        model(op, x, y, eLo, eHi, eDz, eLat);
        startOp(op, x, y);
        checkVal($sformatf("%s.accBusy", tag), 64'(busy), 64'(eLat > 1));
        checkVal($sformatf("%s.accDbz", tag), 64'(div_by_zero), 64'(eDz));
        waitDone(n, bc, intrudeAt);
        checkVal($sformatf("%s.latency", tag), 64'(n + 1), 64'(eLat));
        checkVal($sformatf("%s.busyCycles", tag), 64'(bc), 64'(eLat - 1));
        checkVal($sformatf("%s.lo", tag), 64'(result_lo), 64'(eLo));
        checkVal($sformatf("%s.hi", tag), 64'(result_hi), 64'(eHi));
        checkVal($sformatf("%s.dbz", tag), 64'(div_by_zero), 64'(eDz));
        checkVal($sformatf("%s.busyAtDone", tag), 64'(busy), 64'(0));
        if (hold) begin
            @(posedge clk); #1;
            checkVal($sformatf("%s.donePulse", tag), 64'(done), 64'(0));
            checkVal($sformatf("%s.holdLo", tag), 64'(result_lo), 64'(eLo));
            checkVal($sformatf("%s.holdHi", tag), 64'(result_hi), 64'(eHi));
        end
    endtask

    initial begin
        int doneSeen, busySeen;
        logic [3:0]   op;
        logic [W-1:0] x, y;
        rst = 1'b0; start = 1'b0; a = '0; b = '0; aluop = '0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst.lo", 64'(result_lo), 64'(0));
        checkVal("rst.hi", 64'(result_hi), 64'(0));
        checkVal("rst.busy", 64'(busy), 64'(0));
        checkVal("rst.done", 64'(done), 64'(0));
        checkVal("rst.dbz", 64'(div_by_zero), 64'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        runCheck("mul7x6", 4'h2, 7, 6, -1, 1'b1);
        runCheck("mulMax", 4'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b1);
        runCheck("div100by7", 4'h3, 100, 7, -1, 1'b1);
        runCheck("div5by9", 4'h3, 5, 9, -1, 1'b1);
        runCheck("div123by0", 4'h3, 123, 0, -1, 1'b1);
        runCheck("mulClrDbz", 4'h2, 9, 9, -1, 1'b1);
        runCheck("mulIntrude", 4'h2, 3, 4, 10, 1'b1);

        start = 1'b1; aluop = 4'h1; a = 5; b = 5;
        @(posedge clk); #1;
        start = 1'b0;
        busySeen = 0;
        repeat (4) begin
            if (busy || done) busySeen++;
            @(posedge clk); #1;
        end
        checkVal("badOp.busy", 64'(busySeen), 64'(0));
        checkVal("badOp.lo", 64'(result_lo), 64'(12));

        startOp(4'h3, 1000, 7);
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkVal("midRst.busy", 64'(busy), 64'(0));
        checkVal("midRst.done", 64'(done), 64'(0));
        checkVal("midRst.lo", 64'(result_lo), 64'(0));
        checkVal("midRst.hi", 64'(result_hi), 64'(0));
        rst = 1'b1;
        doneSeen = 0; busySeen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) doneSeen++;
            if (busy) busySeen++;
        end
        checkVal("midRst.noDone", 64'(doneSeen), 64'(0));
        checkVal("midRst.noBusy", 64'(busySeen), 64'(0));

        runCheck("b2bFirst", 4'h2, 1234, 5678, -1, 1'b0);
        runCheck("b2bSecond", 4'h3, 1000000, 37, -1, 1'b0);
        runCheck("b2bDbz", 4'h3, 77, 0, -1, 1'b0);
        runCheck("b2bAfterDbz", 4'h3, 32'hFFFFFFFF, 1, -1, 1'b1);

        for (int i = 0; i < 12; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 4'h2 : 4'h3;
            x  = $urandom;
            case ($urandom_range(0, 3))
                0:       y = '0;
                1:       y = W'($urandom_range(1, 255));
                default: y = $urandom;
            endcase
            runCheck($sformatf("rand%0d", i), op, x, y, -1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
